// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Receiver-side and consumer-side signal bundle for the
//                uart_rx_fifo byte buffer. The slave modport is the buffer
//                itself; the master modport is the surrounding logic.
//                o_drop_cnt exists only when UART_RX_FIFO_DROPCNT_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16
);
    logic [7:0]               i_data;
    logic                     i_rcv;
    logic [7:0]               o_data;
    logic                     o_valid;
    logic                     i_ready;
    logic [$clog2(DEPTH):0]   o_level;
    logic                     o_afull;
    logic                     o_overrun;
    logic                     i_clr_overrun;
`ifdef UART_RX_FIFO_DROPCNT_EN
    logic [7:0]               o_drop_cnt;
`endif

    modport master (
        output i_data,
        output i_rcv,
        output i_ready,
        output i_clr_overrun,
        input  o_data,
        input  o_valid,
        input  o_level,
        input  o_afull,
`ifdef UART_RX_FIFO_DROPCNT_EN
        input  o_drop_cnt,
`endif
        input  o_overrun
    );

    modport slave (
        input  i_data,
        input  i_rcv,
        input  i_ready,
        input  i_clr_overrun,
        output o_data,
        output o_valid,
        output o_level,
        output o_afull,
`ifdef UART_RX_FIFO_DROPCNT_EN
        output o_drop_cnt,
`endif
        output o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Circular byte buffer behind the UART receiver. Captures each
//                one-cycle receive strobe, presents bytes in order on a
//                valid/ready handshake, and raises a sticky overrun flag when
//                a byte arrives with no free slot.
//                Optional feature macro: UART_RX_FIFO_DROPCNT_EN adds an
//                8-bit saturating drop counter on o_drop_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int AFULL = 12
) (
    input  logic              clk,
    input  logic              rstn,
    uart_rx_fifo_if.slave     bus
);
    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_DEPTH = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W:0]   c_AFULL = (c_PTR_W + 1)'(AFULL);

    logic [7:0]          r_mem [DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_PTR_W:0]    r_level;
    logic                r_overrun;

    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // A full buffer still accepts a byte when the head leaves in the same cycle
    assign w_valid = (r_level != '0);
    assign w_full  = (r_level == c_DEPTH);
    assign w_pop   = w_valid & bus.i_ready;
    assign w_push  = bus.i_rcv & (~w_full | w_pop);
    assign w_drop  = bus.i_rcv & w_full & ~w_pop;

    // Byte storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Occupancy tracks push/pop; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky overrun: a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (bus.i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_DROPCNT_EN
    logic [7:0] r_drop_cnt;

    // Saturating drop count; a coincident clear restarts counting at this drop
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_drop_cnt <= 8'h00;
        end else if (w_drop) begin
            if (bus.i_clr_overrun) begin
                r_drop_cnt <= 8'h01;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'h01;
            end
        end else if (bus.i_clr_overrun) begin
            r_drop_cnt <= 8'h00;
        end
    end

    assign bus.o_drop_cnt = r_drop_cnt;
`endif

    // Head byte is read straight from storage and forced to zero when empty
    assign bus.o_data    = w_valid ? r_mem[r_rptr] : 8'h00;
    assign bus.o_valid   = w_valid;
    assign bus.o_level   = r_level;
    assign bus.o_afull   = (r_level >= c_AFULL);
    assign bus.o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. A driver issues
//                directed and random cycles and pushes every accepted byte
//                into an expected queue; a monitor on the falling edge pops
//                that queue whenever the DUT hands a byte over and also checks
//                level, flags and (when UART_RX_FIFO_DROPCNT_EN is defined)
//                the drop counter against a queue/counter reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic clk;
    logic rstn;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .AFULL (AFULL)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the buffer content is exp_q, the rest is plain counters
    logic [7:0] exp_q[$];
    int         m_level = 0;
    bit         m_ovr   = 1'b0;
    int         m_cnt   = 0;
    bit         mon_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle starting just after a rising edge; the model steps at the next edge
    task automatic step(input bit rcv, input logic [7:0] d, input bit rdy,
                        input bit clr, input bit rst_n);
        bit p_pop, p_push, p_drop;
        rstn              = rst_n;
        bus.i_rcv         = rcv;
        bus.i_data        = d;
        bus.i_ready       = rdy;
        bus.i_clr_overrun = clr;
        p_pop  = (m_level > 0) && rdy;
        p_push = rcv && ((m_level < DEPTH) || p_pop);
        p_drop = rcv && !p_push;
        if (rst_n && p_push) exp_q.push_back(d);
        @(posedge clk);
        if (!rst_n) begin
            m_level = 0;
            m_ovr   = 1'b0;
            m_cnt   = 0;
            exp_q.delete();
        end else begin
            m_level = m_level + int'(p_push) - int'(p_pop);
            if (p_drop) begin
                m_ovr = 1'b1;
                m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
            end else if (clr) begin
                m_ovr = 1'b0;
                m_cnt = 0;
            end
        end
        #1;
    endtask

    // Monitor: compare state every cycle and consume one expected byte per handover
    always @(negedge clk) begin
        if (mon_en) begin
            chk("level",   int'(bus.o_level),   m_level);
            chk("valid",   int'(bus.o_valid),   int'(m_level > 0));
            chk("afull",   int'(bus.o_afull),   int'(m_level >= AFULL));
            chk("overrun", int'(bus.o_overrun), int'(m_ovr));
`ifdef UART_RX_FIFO_DROPCNT_EN
            chk("drop_cnt", int'(bus.o_drop_cnt), m_cnt);
`endif
            if (!bus.o_valid) begin
                chk("data_empty", int'(bus.o_data), 0);
            end else if (exp_q.size() == 0) begin
                chk("scoreboard_underflow", 1, 0);
            end else if (rstn && bus.i_ready) begin
                chk("pop_data", int'(bus.o_data), int'(exp_q.pop_front()));
            end else begin
                chk("head_data", int'(bus.o_data), int'(exp_q[0]));
            end
        end
    end

    initial begin
        rstn              = 1'b0;
        bus.i_rcv         = 1'b0;
        bus.i_data        = 8'h00;
        bus.i_ready       = 1'b0;
        bus.i_clr_overrun = 1'b0;
        @(posedge clk);
        #1;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        mon_en = 1'b1;
        chk("reset_valid", int'(bus.o_valid), 0);
        chk("reset_data",  int'(bus.o_data),  0);

        // Single byte in and out
        step(1, 8'hA5, 0, 0, 1);
        chk("a5_valid", int'(bus.o_valid), 1);
        chk("a5_data",  int'(bus.o_data),  8'hA5);
        chk("a5_level", int'(bus.o_level), 1);
        step(0, 8'h00, 1, 0, 1);
        chk("a5_popped_valid", int'(bus.o_valid), 0);
        chk("a5_popped_data",  int'(bus.o_data),  0);

        // Fill to full, watching the almost-full threshold
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 0, 1);
            if (i == AFULL - 2) chk("afull_below", int'(bus.o_afull), 0);
            if (i == AFULL - 1) chk("afull_at",    int'(bus.o_afull), 1);
        end
        chk("full_level", int'(bus.o_level), 16);
        step(1, 8'hFF, 0, 0, 1);
        chk("drop_overrun", int'(bus.o_overrun), 1);
        chk("drop_level",   int'(bus.o_level),   16);

        // Push with simultaneous pop at full: no drop, 0x55 goes to the tail
        step(1, 8'h55, 1, 0, 1);
        chk("full_pushpop_level", int'(bus.o_level), 16);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 1);
        chk("drained", int'(bus.o_valid), 0);

        // Sustained push+pop across pointer wrap
        for (int i = 0; i < 4; i++) step(1, 8'(8'h80 + i), 0, 0, 1);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(8'h10 + i), 1, 0, 1);
            chk("stream_level", int'(bus.o_level), 4);
        end

        // Drop coinciding with clear keeps the flag; a lone clear resets it
        step(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < DEPTH - 4; i++) step(1, 8'(8'hC0 + i), 0, 0, 1);
        step(1, 8'hEE, 0, 1, 1);
        chk("drop_clr_overrun", int'(bus.o_overrun), 1);
        step(0, 8'h00, 0, 1, 1);
        chk("clr_overrun", int'(bus.o_overrun), 0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 1);

        // Reset mid-transfer, with a strobe in the reset cycle
        for (int i = 0; i < 5; i++) step(1, 8'(8'h60 + i), 0, 0, 1);
        step(1, 8'h77, 0, 0, 0);
        chk("rst_valid",   int'(bus.o_valid),   0);
        chk("rst_level",   int'(bus.o_level),   0);
        chk("rst_overrun", int'(bus.o_overrun), 0);
        step(1, 8'h3C, 0, 0, 1);
        chk("after_rst_data", int'(bus.o_data), 8'h3C);

        // Random traffic in phases with different producer/consumer biases
        for (int ph = 0; ph < 6; ph++) begin
            int prcv;
            int prdy;
            prcv = 20 + 15 * ph;
            prdy = 95 - 15 * ph;
            for (int i = 0; i < 500; i++) begin
                step($urandom_range(99) < prcv, 8'($urandom), $urandom_range(99) < prdy,
                     $urandom_range(19) == 0, $urandom_range(399) != 0);
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver strobes out and holds it in a circular buffer. It presents the bytes in order to the consumer through a valid/ready handshake, and it flags bytes that arrive while the buffer is full. This decouples the one-cycle receiver strobe from consumers that cannot accept data every cycle.

## Interface
- `DEPTH`, default 16: number of byte slots. Must be a power of two and ≥ 2.
- `AFULL`, default 12: level at or above which `o_afull` asserts. Range 1..DEPTH.
- `clk`  in  1: sole clock, rising edge.
- `rstn`  in  1: reset. Synchronous, active-low.
- `i_data`  in  8: byte from the receiver. Sampled only when `i_rcv`=1.
- `i_rcv`  in  1: one-cycle write strobe from the receiver.
- `o_data`  out  8: byte at the head of the buffer. 8'h00 whenever `o_valid`=0.
- `o_valid`  out  1: buffer holds at least one byte.
- `i_ready`  in  1: consumer accepts the head byte.
- `o_level`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `o_afull`  out  1: `o_level` ≥ `AFULL`.
- `o_overrun`  out  1: sticky flag; a byte was dropped.
- `i_clr_overrun`  in  1: clears `o_overrun` (and the drop counter, if compiled in).
- `o_drop_cnt`  out  8: present only with `UART_RX_FIFO_DROPCNT_EN`.

## Operation
- Storage: DEPTH×8 register array.
  - Write pointer and read pointer are each $clog2(DEPTH) bits. They wrap naturally modulo DEPTH.
  - Occupancy counter is $clog2(DEPTH)+1 bits.
- Push: `i_rcv`=1 and (level < DEPTH, or a pop happens in the same cycle).
  - Writes `i_data` at the write pointer and increments the write pointer.
- Pop: `o_valid`=1 and `i_ready`=1. Increments the read pointer.
- Level update:
  - Push only: +1.
  - Pop only: −1.
  - Both: unchanged.
  - Neither: unchanged.
- Push when full with no simultaneous pop:
  - The byte is discarded.
  - Pointers and level are unchanged.
  - `o_overrun` sets.
- A push into an empty buffer never bypasses storage.
  - The byte becomes visible on `o_data` only after the write edge.
- `o_overrun`:
  - Set by a drop.
  - Cleared by `i_clr_overrun`.
  - If a drop and a clear occur in the same cycle, the set wins.
- `i_ready` while `o_valid`=0 is ignored.
- `o_data` is a combinational read of the head slot, gated to 8'h00 when empty. It is stable while `o_valid`=1 and no pop occurs.

## Timing
- Reset (`rstn`=0 at a rising edge):
  - Pointers, level and `o_overrun` are cleared to 0.
  - Outputs: `o_valid`=0, `o_data`=8'h00, `o_level`=0, `o_afull`=0, `o_overrun`=0, `o_drop_cnt`=0.
  - Array contents are not cleared.
  - Reset mid-transfer discards all buffered bytes. A strobe in the reset cycle is lost and does not set `o_overrun`.
- Write latency: `i_rcv` sampled at edge N → `o_valid`, `o_level` and `o_data` reflect the byte from edge N onward (visible during cycle N+1).
- Pop: the head advances at the accepting edge. The next byte, or empty, is shown in the following cycle.
- Throughput: one push and one pop per cycle, sustained.
- `o_afull` and `o_level` are derived from the registered count. They have no extra latency beyond the count.
- Full boundary:
  - At level=DEPTH, a simultaneous push and pop keeps level at DEPTH with no drop.
  - The wrap of both pointers is seamless.
- Empty boundary: at level=0, a push with `i_ready`=1 does not pop in that cycle.

## Configuration
- `UART_RX_FIFO_DROPCNT_EN` defined:
  - Adds the output `o_drop_cnt`[7:0].
  - It increments on every dropped byte and saturates at 255.
  - `i_clr_overrun` zeroes it. If a drop and a clear coincide, the result is 1.
- Not defined: the port and counter are absent. `o_overrun` behaves identically.

## Test plan
- Reset, then push 8'hA5: cycle after the strobe shows `o_valid`=1, `o_data`=8'hA5, `o_level`=1. Pop with `i_ready`=1, then `o_valid`=0 and `o_data`=8'h00.
- DEPTH=16, push 8'h00..8'h0F with `i_ready`=0:
  - `o_afull` asserts after the 12th push and `o_level`=16.
  - A 17th push of 8'hFF sets `o_overrun`. `o_drop_cnt`=1 when enabled.
  - Draining yields 8'h00..8'h0F in order.
- With the buffer full, strobe 8'h55 with `i_ready`=1 in the same cycle: no overrun, `o_level` stays 16, and 8'h55 emerges last.
- Push and pop on every cycle for 40 cycles with an incrementing pattern:
  - `o_level` stays constant and no drops occur.
  - Data order is preserved across pointer wrap.
- Assert drop and `i_clr_overrun` in the same cycle: `o_overrun` stays 1. A clear alone then returns it to 0 and `o_drop_cnt` to 0.
- Fill to 5 bytes, then assert `rstn`=0 for one cycle: `o_valid`=0, `o_level`=0, `o_overrun`=0. The next push of 8'h3C is read back first.
